// File: rtl/acquisition_sequencer_if.sv
// acquisition_sequencer_if: host control, trigger-hub handshake and capture RAM
// write port of the acquisition sequencer, grouped in one bundle.
// master = host / hub / RAM side, slave = the sequencer itself.
interface acquisition_sequencer_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  start;
  logic                  stop;
  logic                  rearm;
  logic                  ack;
  logic [ADDR_WIDTH-1:0] pre_count;
  logic [ADDR_WIDTH-1:0] post_count;
  logic                  sample_valid;
  logic [1:0]            trigger_state;
  logic                  hub_arm;
  logic                  hub_reset;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] trig_addr;
  logic [ADDR_WIDTH-1:0] start_addr;
  logic                  busy;
  logic                  done;
  logic                  capture_valid;
  logic                  timed_out;

  modport master (
    output start, stop, rearm, ack, pre_count, post_count, sample_valid, trigger_state,
    input  hub_arm, hub_reset, wr_en, wr_addr, trig_addr, start_addr,
           busy, done, capture_valid, timed_out
  );

  modport slave (
    input  start, stop, rearm, ack, pre_count, post_count, sample_valid, trigger_state,
    output hub_arm, hub_reset, wr_en, wr_addr, trig_addr, start_addr,
           busy, done, capture_valid, timed_out
  );
endinterface

// File: rtl/acquisition_sequencer.sv
// acquisition_sequencer: runs one capture cycle around the trigger hub.
// Prefills the circular capture buffer with pre_count samples, arms the hub,
// waits for the trigger, collects post_count samples (trigger sample is
// post sample 0) and holds the buffer until the host acknowledges.
// Optional feature: define ACQ_SEQ_AUTO_TRIGGER_EN to force a trigger after
// AUTO_TIMEOUT cycles in ARMED (sets timed_out).
module acquisition_sequencer #(
  parameter int ADDR_WIDTH   = 10,
  parameter int AUTO_TIMEOUT = 1000000
) (
  input logic                   clk,
  input logic                   rst,
  acquisition_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    HOLD
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [ADDR_WIDTH-1:0] cnt_inc;
  logic [ADDR_WIDTH-1:0] pre_lat;
  logic [ADDR_WIDTH-1:0] post_lat;
  logic                  hub_trig;
  logic                  force_trig;
  logic                  post_full;
  logic                  post_last;

  assign cnt_inc   = cnt + 1'b1;
  assign hub_trig  = (bus.trigger_state == 2'b10) || (bus.trigger_state == 2'b11);
  // Post quota can already be met on POST entry (trigger write counted, or post_count = 0).
  assign post_full = (cnt == post_lat);
  assign post_last = post_full || (bus.sample_valid && (cnt_inc == post_lat));

  // NOTE: wr_en is combinational so the RAM sees a sample in the same cycle it arrives.
  assign bus.wr_en   = bus.sample_valid &&
                       ((state == PREFILL) || (state == ARMED) || ((state == POST) && !post_full));
  assign bus.wr_addr = ptr;

`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
  logic [31:0] to_cnt;

  // Cycles spent in ARMED; cleared whenever the sequencer is anywhere else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == ARMED) begin
      to_cnt <= to_cnt + 32'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign force_trig = (state == ARMED) && (to_cnt == 32'(AUTO_TIMEOUT - 1));
`else
  // Auto-trigger not built: ARMED waits for the hub indefinitely (condition is always false).
  assign force_trig = (AUTO_TIMEOUT < 0);
`endif

  // Sequencer FSM with all registered outputs; stop overrides every other input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: asynchronous reset clears every register, so outputs drop without waiting for clk.
      state             <= IDLE;
      ptr               <= '0;
      cnt               <= '0;
      pre_lat           <= '0;
      post_lat          <= '0;
      bus.hub_arm       <= 1'b0;
      bus.hub_reset     <= 1'b0;
      bus.trig_addr     <= '0;
      bus.start_addr    <= '0;
      bus.busy          <= 1'b0;
      bus.done          <= 1'b0;
      bus.capture_valid <= 1'b0;
      bus.timed_out     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout; later assignments in this block win.
      bus.hub_reset <= 1'b0;
      bus.done      <= 1'b0;
      if (bus.wr_en) begin
        ptr <= ptr + 1'b1;
      end

      if (bus.stop) begin
        state             <= IDLE;
        bus.hub_arm       <= 1'b0;
        bus.hub_reset     <= 1'b1;
        bus.busy          <= 1'b0;
        bus.capture_valid <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (bus.start) begin
              state         <= PREFILL;
              ptr           <= '0;
              cnt           <= '0;
              pre_lat       <= bus.pre_count;
              post_lat      <= bus.post_count;
              bus.hub_reset <= 1'b1;
              bus.timed_out <= 1'b0;
              bus.busy      <= 1'b1;
            end
          end

          PREFILL: begin
            if (pre_lat == '0) begin
              state       <= ARMED;
              bus.hub_arm <= 1'b1;
            end else if (bus.sample_valid) begin
              cnt <= cnt_inc;
              if (cnt_inc == pre_lat) begin
                state       <= ARMED;
                bus.hub_arm <= 1'b1;
              end
            end
          end

          ARMED: begin
            if (hub_trig || force_trig) begin
              state         <= POST;
              bus.trig_addr <= ptr;
              bus.hub_arm   <= 1'b0;
              // A write in the trigger cycle lands at trig_addr and is post sample 0.
              cnt           <= (bus.sample_valid && (post_lat != '0)) ? ADDR_WIDTH'(1) : '0;
              if (!hub_trig) begin
                bus.timed_out <= 1'b1;
              end
            end
          end

          POST: begin
            if (!post_full && bus.sample_valid) begin
              cnt <= cnt_inc;
            end
            if (post_last) begin
              state             <= HOLD;
              bus.done          <= 1'b1;
              bus.hub_reset     <= 1'b1;
              bus.capture_valid <= 1'b1;
              bus.start_addr    <= bus.trig_addr - pre_lat;
            end
          end

          HOLD: begin
            if (bus.ack) begin
              bus.capture_valid <= 1'b0;
              if (bus.rearm) begin
                state    <= PREFILL;
                cnt      <= '0;
                pre_lat  <= bus.pre_count;
                post_lat <= bus.post_count;
              end else begin
                state    <= IDLE;
                bus.busy <= 1'b0;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_acquisition_sequencer.sv
// tb_acquisition_sequencer: directed bench for acquisition_sequencer with
// ADDR_WIDTH=4, AUTO_TIMEOUT=20. Expected write addresses are queued as each
// write cycle is driven and compared at the falling edge when wr_en fires.
module tb_acquisition_sequencer;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acquisition_sequencer_if #(.ADDR_WIDTH(AW)) sif ();

  acquisition_sequencer #(
    .ADDR_WIDTH  (AW),
    .AUTO_TIMEOUT(20)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif.slave)
  );

  int            tests = 0;
  int            fails = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_ptr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Queue the address of a write that happens in the current cycle.
  task automatic push_w();
    exp_q.push_back(exp_ptr);
    exp_ptr = exp_ptr + 1'b1;
  endtask

  // Scoreboard: every RAM write must match the next queued address.
  always @(negedge clk) begin
    if (rst === 1'b0 && sif.wr_en === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(sif.wr_addr), 32'hFFFF_FFFF);
      else check("wr_addr", 32'(sif.wr_addr), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst               = 1'b1;
    sif.start         = 1'b0;
    sif.stop          = 1'b0;
    sif.rearm         = 1'b0;
    sif.ack           = 1'b0;
    sif.pre_count     = '0;
    sif.post_count    = '0;
    sif.sample_valid  = 1'b0;
    sif.trigger_state = 2'b00;
    exp_ptr           = '0;
    cyc(2);
    check("rst_busy", 32'(sif.busy), 0);
    check("rst_hub_arm", 32'(sif.hub_arm), 0);
    check("rst_hub_reset", 32'(sif.hub_reset), 0);
    check("rst_wr_addr", 32'(sif.wr_addr), 0);
    check("rst_flags", {28'd0, sif.done, sif.capture_valid, sif.timed_out, sif.wr_en}, 0);
    rst = 1'b0;
    cyc();

    // ---- Capture 1: pre=4 post=3, trigger 10 cycles after arm
    sif.pre_count    = 4'd4;
    sif.post_count   = 4'd3;
    sif.sample_valid = 1'b1;
    sif.start        = 1'b1;
    cyc();
    sif.start = 1'b0;
    check("c1_busy", 32'(sif.busy), 1);
    check("c1_hub_reset", 32'(sif.hub_reset), 1);
    exp_ptr = '0;
    for (int i = 0; i < 4; i++) begin
      push_w();
      if (i == 3) check("c1_prefill_hub_arm", 32'(sif.hub_arm), 0);
      cyc();
    end
    check("c1_armed_hub_arm", 32'(sif.hub_arm), 1);
    check("c1_hub_reset_gone", 32'(sif.hub_reset), 0);
    sif.trigger_state = 2'b01;
    for (int i = 0; i < 10; i++) begin
      push_w();
      cyc();
    end
    check("c1_trig_cycle_addr", 32'(sif.wr_addr), 14);
    sif.trigger_state = 2'b10;
    push_w();
    cyc();
    sif.trigger_state = 2'b00;
    check("c1_post_hub_arm", 32'(sif.hub_arm), 0);
    check("c1_trig_addr", 32'(sif.trig_addr), 14);
    check("c1_post_done", 32'(sif.done), 0);
    push_w();
    cyc();
    push_w();
    cyc();
    check("c1_done", 32'(sif.done), 1);
    check("c1_capture_valid", 32'(sif.capture_valid), 1);
    check("c1_start_addr", 32'(sif.start_addr), 10);
    check("c1_hold_hub_reset", 32'(sif.hub_reset), 1);
    check("c1_hold_wr_en", 32'(sif.wr_en), 0);
    cyc();
    check("c1_done_pulse", 32'(sif.done), 0);
    check("c1_hold_valid", 32'(sif.capture_valid), 1);
    check("c1_queue_empty", 32'(exp_q.size()), 0);
    sif.ack = 1'b1;
    cyc();
    sif.ack = 1'b0;
    check("c1_ack_busy", 32'(sif.busy), 0);
    check("c1_ack_valid", 32'(sif.capture_valid), 0);
    check("c1_ack_no_reset", 32'(sif.hub_reset), 0);

    // ---- Capture 2: pre=0 post=0, immediate trigger
    sif.pre_count  = 4'd0;
    sif.post_count = 4'd0;
    sif.start      = 1'b1;
    cyc();
    sif.start = 1'b0;
    exp_ptr   = '0;
    check("c2_prefill_hub_arm", 32'(sif.hub_arm), 0);
    push_w();
    cyc();
    check("c2_armed_hub_arm", 32'(sif.hub_arm), 1);
    sif.trigger_state = 2'b10;
    push_w();
    cyc();
    sif.trigger_state = 2'b00;
    check("c2_trig_addr", 32'(sif.trig_addr), 1);
    check("c2_post_no_write", 32'(sif.wr_en), 0);
    cyc();
    check("c2_done", 32'(sif.done), 1);
    check("c2_start_addr", 32'(sif.start_addr), 1);

    // ---- Rearm with new counts (pre=2 post=1), then stop in ARMED
    sif.pre_count  = 4'd2;
    sif.post_count = 4'd1;
    sif.ack        = 1'b1;
    sif.rearm      = 1'b1;
    cyc();
    sif.ack   = 1'b0;
    sif.rearm = 1'b0;
    check("rearm_busy", 32'(sif.busy), 1);
    check("rearm_no_hub_reset", 32'(sif.hub_reset), 0);
    check("rearm_valid_low", 32'(sif.capture_valid), 0);
    push_w();
    cyc();
    check("rearm_prefill_hub_arm", 32'(sif.hub_arm), 0);
    push_w();
    cyc();
    check("rearm_armed_hub_arm", 32'(sif.hub_arm), 1);
    sif.stop = 1'b1;
    push_w();
    cyc();
    sif.stop = 1'b0;
    check("stop_armed_busy", 32'(sif.busy), 0);
    check("stop_armed_hub_arm", 32'(sif.hub_arm), 0);
    check("stop_armed_hub_reset", 32'(sif.hub_reset), 1);

    // ---- Capture 3: stop together with ack (and rearm) in HOLD
    sif.pre_count  = 4'd0;
    sif.post_count = 4'd1;
    sif.start      = 1'b1;
    cyc();
    sif.start = 1'b0;
    exp_ptr   = '0;
    push_w();
    cyc();
    sif.trigger_state = 2'b11;
    push_w();
    cyc();
    sif.trigger_state = 2'b00;
    check("c3_post1_no_write", 32'(sif.wr_en), 0);
    cyc();
    check("c3_hold_valid", 32'(sif.capture_valid), 1);
    sif.stop  = 1'b1;
    sif.ack   = 1'b1;
    sif.rearm = 1'b1;
    cyc();
    sif.stop  = 1'b0;
    sif.ack   = 1'b0;
    sif.rearm = 1'b0;
    check("stop_ack_busy", 32'(sif.busy), 0);
    check("stop_ack_valid", 32'(sif.capture_valid), 0);
    check("stop_ack_hub_reset", 32'(sif.hub_reset), 1);
    check("stop_ack_hub_arm", 32'(sif.hub_arm), 0);
    cyc();
    check("idle_hub_reset_low", 32'(sif.hub_reset), 0);
    sif.stop = 1'b1;
    cyc();
    sif.stop = 1'b0;
    check("stop_idle_hub_reset", 32'(sif.hub_reset), 1);

    // ---- Capture 4: reset during POST, then a clean pre=1 post=1 capture
    sif.pre_count  = 4'd2;
    sif.post_count = 4'd5;
    sif.start      = 1'b1;
    cyc();
    sif.start = 1'b0;
    exp_ptr   = '0;
    push_w();
    cyc();
    push_w();
    cyc();
    sif.trigger_state = 2'b10;
    push_w();
    cyc();
    sif.trigger_state = 2'b00;
    rst = 1'b1;
    #1;
    check("rst_post_busy", 32'(sif.busy), 0);
    check("rst_post_wr_en", 32'(sif.wr_en), 0);
    check("rst_post_wr_addr", 32'(sif.wr_addr), 0);
    check("rst_post_trig_addr", 32'(sif.trig_addr), 0);
    cyc();
    rst = 1'b0;
    cyc();
    sif.pre_count  = 4'd1;
    sif.post_count = 4'd1;
    sif.start      = 1'b1;
    cyc();
    sif.start = 1'b0;
    exp_ptr   = '0;
    push_w();
    cyc();
    sif.trigger_state = 2'b10;
    push_w();
    cyc();
    sif.trigger_state = 2'b00;
    cyc();
    check("c4_done", 32'(sif.done), 1);
    check("c4_trig_addr", 32'(sif.trig_addr), 1);
    check("c4_start_addr", 32'(sif.start_addr), 0);
    sif.ack = 1'b1;
    cyc();
    sif.ack = 1'b0;

    // ---- Capture 5: no trigger from the hub
    sif.pre_count  = 4'd1;
    sif.post_count = 4'd2;
    sif.start      = 1'b1;
    cyc();
    sif.start = 1'b0;
    exp_ptr   = '0;
    push_w();
    cyc();
    sif.trigger_state = 2'b01;
`ifdef ACQ_SEQ_AUTO_TRIGGER_EN
    for (int i = 0; i < 19; i++) begin
      push_w();
      cyc();
    end
    check("to_still_armed", 32'(sif.hub_arm), 1);
    check("to_not_yet", 32'(sif.timed_out), 0);
    push_w();
    cyc();
    check("to_post_hub_arm", 32'(sif.hub_arm), 0);
    check("to_timed_out", 32'(sif.timed_out), 1);
    check("to_trig_addr", 32'(sif.trig_addr), 4);
    push_w();
    cyc();
    check("to_done", 32'(sif.done), 1);
    check("to_start_addr", 32'(sif.start_addr), 3);
    sif.ack = 1'b1;
    cyc();
    sif.ack   = 1'b0;
    sif.start = 1'b1;
    cyc();
    sif.start = 1'b0;
    check("to_cleared_on_start", 32'(sif.timed_out), 0);
    exp_ptr  = '0;
    push_w();
    sif.stop = 1'b1;
    cyc();
    sif.stop = 1'b0;
`else
    for (int i = 0; i < 25; i++) begin
      push_w();
      cyc();
    end
    check("noto_hub_arm", 32'(sif.hub_arm), 1);
    check("noto_timed_out", 32'(sif.timed_out), 0);
    check("noto_valid", 32'(sif.capture_valid), 0);
    sif.stop = 1'b1;
    push_w();
    cyc();
    sif.stop = 1'b0;
`endif
    check("c5_stopped", 32'(sif.busy), 0);
    sif.sample_valid  = 1'b0;
    sif.trigger_state = 2'b00;
    cyc(2);
    check("final_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
